// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-port word memory.
// Loads take three cycles to respond; word stores take two; byte and half
// stores use read-modify-write and take five. Lanes are little-endian.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_we/size/unsigned     access kind; size 00 byte, 01 half, 10 word
//   req_addr/req_wdata       byte address, right-aligned store data
//   resp_valid/rdata/err     one-cycle completion pulse and load result
//   mem_wen/waddr/wdata      memory write port (word addressed)
//   mem_ren/raddr/rdata      memory read port, data one cycle after ren
//
// Macro LSU_ALIGN_CHECK_EN: when defined, illegal size and misaligned
// half/word requests are rejected with resp_err and no memory access.
// When undefined, addresses are force-aligned and size 11 acts as word.
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, RD, DATA, MERGE, WR, RESP
    } state_t;

    state_t state, state_nx;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
`ifdef LSU_ALIGN_CHECK_EN
    logic              err_q;
`endif

    logic        accept;
    logic [1:0]  size_n;
    logic [1:0]  off_n;
    logic        bad;
    logic [31:0] shifted;
    logic [31:0] ld;
    logic [31:0] mask;
    logic [31:0] lane;
    logic [31:0] merged;

    // Upper address bits lie outside the memory and are dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign accept = (state == IDLE) && req_valid;

    // Normalise size and lane offset at capture so later stages
    // never see a misaligned sub-word offset.
    always_comb begin
        size_n = (req_size == 2'b11) ? 2'b10 : req_size;
        case (size_n)
            2'b00:   off_n = req_addr[1:0];
            2'b01:   off_n = {req_addr[1], 1'b0};
            default: off_n = 2'b00;
        endcase
`ifdef LSU_ALIGN_CHECK_EN
        bad = (req_size == 2'b11)
            || ((req_size == 2'b01) && req_addr[0])
            || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        bad = 1'b0;
`endif
    end

    // Load extraction from the word returned by memory.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00: ld = uns_q ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: ld = uns_q ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
            default: ld = mem_rdata;
        endcase
    end

    // Sub-word store lane merged into the previously read word.
    always_comb begin
        if (size_q == 2'b00) begin
            mask = 32'h0000_00FF << {off_q, 3'b000};
            lane = {4{wdata_q[7:0]}};
        end else begin
            mask = 32'h0000_FFFF << {off_q, 3'b000};
            lane = {2{wdata_q[15:0]}};
        end
        merged = (buf_q & ~mask) | (lane & mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad)
                        state_nx = RESP;
                    else if (req_we && (size_n == 2'b10))
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = DATA;
            DATA:    state_nx = we_q ? MERGE : RESP;
            MERGE:   state_nx = WR;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            buf_q   <= 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= size_n;
                uns_q   <= req_unsigned;
                off_q   <= off_n;
                addr_q  <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
                err_q   <= bad;
`endif
            end
            // Stores keep the raw word for merging; loads keep the result.
            if (state == DATA)
                buf_q <= we_q ? mem_rdata : ld;
            if (state == MERGE)
                wdata_q <= merged;
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        mem_ren    = (state == RD);
        mem_wen    = (state == WR);
        mem_wdata  = (state == WR) ? wdata_q : 32'h0;
        mem_raddr  = (state == IDLE) ? '0 : addr_q;
        mem_waddr  = (state == IDLE) ? '0 : addr_q;
        resp_valid = (state == RESP);
        resp_rdata = 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
        resp_err = (state == RESP) && err_q;
        if ((state == RESP) && !we_q && !err_q)
            resp_rdata = buf_q;
`else
        resp_err = 1'b0;
        if ((state == RESP) && !we_q)
            resp_rdata = buf_q;
`endif
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests, a shadow
// memory model of expected responses, and literal spot values.
module tb_load_store_unit;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_wen;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_waddr    (mem_waddr),
        .mem_raddr    (mem_raddr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory environment: registered read, synchronous write.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_acc = 0;
    always @(posedge clk)
        if (!rst && req_valid && req_ready) n_acc <= n_acc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      name, act, exp, $time);
    endtask

    typedef struct {
        int          cyc;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nr;
        int          nw;
        logic        st;
        int          word;
    } exp_t;

    exp_t        q[$];
    logic [31:0] shadow [int];

    function automatic logic [31:0] sh_get(input int w);
        return shadow.exists(w) ? shadow[w] : 32'h0;
    endfunction

    // Expected outcome of one request, straight from the access rules.
    task automatic model(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        int          w;
        int          bsh;
        int          hsh;
        logic [31:0] old;
        logic [31:0] v;
        logic [1:0]  s;
        logic        bad;
        w   = int'(a[17:2]);
        old = sh_get(w);
        bsh = 8 * int'(a[1:0]);
        hsh = 16 * int'(a[1]);
        s   = sz;
`ifdef LSU_ALIGN_CHECK_EN
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0])
           || (sz == 2'd2 && a[1:0] != 2'd0);
`else
        bad = 1'b0;
        if (sz == 2'd3) s = 2'd2;
`endif
        e.cyc = 0; e.rdata = 32'h0; e.err = 1'b0;
        e.nr = 0; e.nw = 0; e.st = 1'b0; e.word = w;
        if (bad) begin
            e.lat = 1;
            e.err = 1'b1;
        end else if (!we) begin
            e.lat = 3;
            e.nr  = 1;
            if (s == 2'd0) begin
                v = (old >> bsh) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (s == 2'd1) begin
                v = (old >> hsh) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = old;
            end
            e.rdata = v;
        end else begin
            e.nw = 1;
            e.st = 1'b1;
            if (s == 2'd2) begin
                e.lat = 2;
                v = wd;
            end else if (s == 2'd0) begin
                e.lat = 5;
                e.nr  = 1;
                v = (old & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
            end else begin
                e.lat = 5;
                e.nr  = 1;
                v = (old & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
            end
            shadow[w] = v;
        end
    endtask

    // Per-cycle compare against the expected-response queue.
    int rcnt = 0;
    int wcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        logic due;
        if (rst) begin
            rcnt = 0;
            wcnt = 0;
        end else begin
            check("wen_ren_excl", 32'(mem_wen & mem_ren), 32'h0);
            if (mem_ren) rcnt++;
            if (mem_wen) wcnt++;
            due = (q.size() > 0) && (q[0].cyc == cyc);
            check("resp_valid", 32'(resp_valid), 32'(due));
            if (due) begin
                e = q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("ren_pulses", rcnt, e.nr);
                check("wen_pulses", wcnt, e.nw);
                if (e.st)
                    check("mem_word", mem[e.word], sh_get(e.word));
                rcnt = 0;
                wcnt = 0;
            end
        end
    end

    // Issue one request from an IDLE negedge; returns at the next IDLE.
    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        exp_t e;
        int   n;
        logic got;
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(req_ready), 32'h1);
        model(we, sz, uns, a, wd, e);
        e.cyc = cyc + e.lat;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            @(negedge clk);
        end
        check("resp_seen", 32'(got), 32'h1);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        exp_t e;
        int   acc0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_wen", 32'(mem_wen), 32'h0);
        check("rst_mem_ren", 32'(mem_ren), 32'h0);
        check("rst_mem_waddr", 32'(mem_waddr), 32'h0);
        check("rst_mem_raddr", 32'(mem_raddr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF, rd, er);
        do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'h80FF_1234, rd, er);
        do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, rd, er);
        do_req(1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFE_F00D, rd, er);
        do_req(1'b1, 2'd2, 1'b0, 32'h0C, 32'h5566_7788, rd, er);

        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, er);
        check("lit_word_load", rd, 32'hDEAD_BEEF);
        check("lit_word_err", 32'(er), 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h07, 32'h0, rd, er);
        check("lit_byte_signed", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h07, 32'h0, rd, er);
        check("lit_byte_unsigned", rd, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h06, 32'h0, rd, er);
        check("lit_half_signed", rd, 32'hFFFF_80FF);
        do_req(1'b0, 2'd0, 1'b0, 32'h04, 32'h0, rd, er);
        check("lit_byte_lane0", rd, 32'h0000_0034);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFC_0014, 32'h0, rd, er);
        check("lit_upper_ignored", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_ABCD, rd, er);
        check("lit_half_rmw", mem[2], 32'hABCD_3344);
        check("lit_store_rdata", rd, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'hFFFF_FF77, rd, er);
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, er);
        check("lit_byte_rmw", rd, 32'hABCD_7744);

`ifdef LSU_ALIGN_CHECK_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, rd, er);
        check("lit_misalign_err", 32'(er), 32'h1);
        check("lit_misalign_rdata", rd, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h14, 32'h0, rd, er);
        check("lit_size3_err", 32'(er), 32'h1);
        do_req(1'b1, 2'd1, 1'b0, 32'h05, 32'h0000_9999, rd, er);
        check("lit_half_odd_err", 32'(er), 32'h1);
        check("lit_half_odd_nowr", mem[1], 32'h80FF_1234);
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, rd, er);
        check("lit_misalign_word", rd, 32'hCAFE_F00D);
        check("lit_misalign_err", 32'(er), 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h16, 32'h0, rd, er);
        check("lit_size3_word", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, rd, er);
        check("lit_half_forced", rd, 32'h0000_1234);
`endif

        // Reset while a byte store sits in its write cycle.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0D; req_wdata = 32'h0000_00AA;
        check("abort_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_wr", 32'(mem_wen), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_wen_drop", 32'(mem_wen), 32'h0);
        check("abort_ready", 32'(req_ready), 32'h1);
        check("abort_no_resp", 32'(resp_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_mem_kept", mem[3], 32'h5566_7788);
        @(negedge clk);

        // Request held valid through a load: one accept, then the next
        // only in the idle cycle after the response.
        acc0 = n_acc;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h14; req_wdata = 32'h0;
        check("hold_ready_first", 32'(req_ready), 32'h1);
        model(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, e);
        e.cyc = cyc + e.lat;
        q.push_back(e);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("hold_busy", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        check("hold_ready_again", 32'(req_ready), 32'h1);
        model(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, e);
        e.cyc = cyc + e.lat;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_accepts", n_acc - acc0, 32'd2);

        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
